// File: rtl/plane_tile_walker_if.sv
// plane_tile_walker_if
//   Bundles every signal of the tile walker except clock and reset.
//   - Triangle command: tri_valid/tri_ready handshake, vertex X/Y/Z
//     (signed fixed point), fraction width and tile column/row.
//   - abort: synchronous cancel of the triangle in flight.
//   - Interpolator side: latched plane inputs ip_f*/ip_frac_bits, the
//     ip_setup strobe, the pixel coordinate ip_x/ip_y and the
//     combinational result ip_z.
//   - Pixel stream: pix_valid/pix_ready handshake with pix_x, pix_y,
//     pix_z and pix_last.
//   - busy: walker is not idle.
// Modports:
//   slave  - the walker itself.
//   master - the environment: command source, interpolator and pixel sink.
interface plane_tile_walker_if;
  logic               tri_valid;
  logic               tri_ready;
  logic signed [31:0] tri_fx1, tri_fx2, tri_fx3;
  logic signed [31:0] tri_fy1, tri_fy2, tri_fy3;
  logic signed [31:0] tri_fz1, tri_fz2, tri_fz3;
  logic        [7:0]  tri_frac_bits;
  logic        [5:0]  tri_tile_x;
  logic        [5:0]  tri_tile_y;
  logic               abort;

  logic signed [31:0] ip_fx1, ip_fx2, ip_fx3;
  logic signed [31:0] ip_fy1, ip_fy2, ip_fy3;
  logic signed [31:0] ip_fz1, ip_fz2, ip_fz3;
  logic        [7:0]  ip_frac_bits;
  logic               ip_setup;
  logic signed [11:0] ip_x;
  logic signed [11:0] ip_y;
  logic signed [31:0] ip_z;

  logic               pix_valid;
  logic               pix_ready;
  logic        [11:0] pix_x;
  logic        [11:0] pix_y;
  logic signed [31:0] pix_z;
  logic               pix_last;

  logic               busy;

  modport slave (
    input  tri_valid,
    input  tri_fx1, tri_fx2, tri_fx3,
    input  tri_fy1, tri_fy2, tri_fy3,
    input  tri_fz1, tri_fz2, tri_fz3,
    input  tri_frac_bits, tri_tile_x, tri_tile_y,
    input  abort,
    input  ip_z,
    input  pix_ready,
    output tri_ready,
    output ip_fx1, ip_fx2, ip_fx3,
    output ip_fy1, ip_fy2, ip_fy3,
    output ip_fz1, ip_fz2, ip_fz3,
    output ip_frac_bits, ip_setup, ip_x, ip_y,
    output pix_valid, pix_x, pix_y, pix_z, pix_last,
    output busy
  );

  modport master (
    output tri_valid,
    output tri_fx1, tri_fx2, tri_fx3,
    output tri_fy1, tri_fy2, tri_fy3,
    output tri_fz1, tri_fz2, tri_fz3,
    output tri_frac_bits, tri_tile_x, tri_tile_y,
    output abort,
    output ip_z,
    output pix_ready,
    input  tri_ready,
    input  ip_fx1, ip_fx2, ip_fx3,
    input  ip_fy1, ip_fy2, ip_fy3,
    input  ip_fz1, ip_fz2, ip_fz3,
    input  ip_frac_bits, ip_setup, ip_x, ip_y,
    input  pix_valid, pix_x, pix_y, pix_z, pix_last,
    input  busy
  );
endinterface

// File: rtl/plane_tile_walker.sv
// plane_tile_walker
//   Accepts one triangle command, hands its plane inputs to an external
//   interpolator, pulses ip_setup, waits SETUP_LAT cycles for the
//   interpolator coefficients, then walks every pixel of one
//   TILE_W x TILE_H tile in raster order, streaming (x, y, z) with
//   pix_last on the final pixel.
// Ports:
//   clock - single clock, rising edge.
//   reset - asynchronous, active-high.
//   bus   - plane_tile_walker_if.slave: triangle command, abort,
//           interpolator signals, pixel stream and busy.
// Parameters:
//   TILE_W, TILE_H - tile size in pixels.
//   SETUP_LAT      - cycles from ip_setup until ip_z is valid (1..15).
module plane_tile_walker #(
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32,
  parameter int SETUP_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  plane_tile_walker_if.slave  bus
);

  localparam int CX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int CY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam logic [CX_W-1:0] CX_MAX   = CX_W'(TILE_W - 1);
  localparam logic [CY_W-1:0] CY_MAX   = CY_W'(TILE_H - 1);
  localparam logic [11:0]     TILE_W12 = 12'(TILE_W);
  localparam logic [11:0]     TILE_H12 = 12'(TILE_H);
  // WAIT lasts SETUP_LAT-1 cycles; the counter runs down to zero and the
  // zero cycle is the last one spent in WAIT.
  localparam logic [3:0]      WAIT_INIT = (SETUP_LAT > 1) ? 4'(SETUP_LAT - 2) : 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    WALK,
    DRAIN
  } state_t;

  state_t            state_reg;
  logic              tri_ready_reg;
  logic              busy_reg;
  logic              ip_setup_reg;
  logic [31:0]       plane_reg [9];
  logic [7:0]        frac_reg;
  logic [5:0]        tile_x_reg;
  logic [5:0]        tile_y_reg;
  logic [CX_W-1:0]   cx_reg;
  logic [CY_W-1:0]   cy_reg;
  logic [3:0]        wait_cnt_reg;
  logic              pix_valid_reg;
  logic              pix_last_reg;
  logic [11:0]       pix_x_reg;
  logic [11:0]       pix_y_reg;
  logic [31:0]       pix_z_reg;

  logic [31:0]       tri_vec [9];
  logic [11:0]       ip_x_calc;
  logic [11:0]       ip_y_calc;
  logic              walk_take;
  logic              at_end;

  // Vertex order in the plane array: X1..X3, Y1..Y3, Z1..Z3.
  assign tri_vec[0] = bus.tri_fx1;
  assign tri_vec[1] = bus.tri_fx2;
  assign tri_vec[2] = bus.tri_fx3;
  assign tri_vec[3] = bus.tri_fy1;
  assign tri_vec[4] = bus.tri_fy2;
  assign tri_vec[5] = bus.tri_fy3;
  assign tri_vec[6] = bus.tri_fz1;
  assign tri_vec[7] = bus.tri_fz2;
  assign tri_vec[8] = bus.tri_fz3;

  // Pixel coordinate is a pure function of held registers, so it stays
  // frozen whenever the counters are frozen (stall, drain).
  assign ip_x_calc = 12'(tile_x_reg) * TILE_W12 + 12'(cx_reg);
  assign ip_y_calc = 12'(tile_y_reg) * TILE_H12 + 12'(cy_reg);

  // A pixel is captured when the output slot is empty or being consumed.
  assign walk_take = (state_reg == WALK) && (!pix_valid_reg || bus.pix_ready);
  assign at_end    = (cx_reg == CX_MAX) && (cy_reg == CY_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      tri_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      ip_setup_reg  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        plane_reg[i] <= '0;
      end
      frac_reg      <= '0;
      tile_x_reg    <= '0;
      tile_y_reg    <= '0;
      cx_reg        <= '0;
      cy_reg        <= '0;
      wait_cnt_reg  <= '0;
      pix_valid_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      pix_z_reg     <= '0;
    end else if (bus.abort) begin
      // Cancel wins over everything; plane and tile registers are kept.
      state_reg     <= IDLE;
      tri_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      ip_setup_reg  <= 1'b0;
      cx_reg        <= '0;
      cy_reg        <= '0;
      wait_cnt_reg  <= '0;
      pix_valid_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
    end else begin
      ip_setup_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.tri_valid && tri_ready_reg) begin
            for (int i = 0; i < 9; i++) begin
              plane_reg[i] <= tri_vec[i];
            end
            frac_reg      <= bus.tri_frac_bits;
            tile_x_reg    <= bus.tri_tile_x;
            tile_y_reg    <= bus.tri_tile_y;
            cx_reg        <= '0;
            cy_reg        <= '0;
            state_reg     <= SETUP;
            tri_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            // Registered strobe: high for the one cycle spent in SETUP.
            ip_setup_reg  <= 1'b1;
          end
        end

        SETUP: begin
          if (SETUP_LAT > 1) begin
            wait_cnt_reg <= WAIT_INIT;
            state_reg    <= WAIT;
          end else begin
            state_reg    <= WALK;
          end
        end

        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= WALK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        WALK: begin
          if (walk_take) begin
            pix_x_reg     <= ip_x_calc;
            pix_y_reg     <= ip_y_calc;
            pix_z_reg     <= bus.ip_z;
            pix_valid_reg <= 1'b1;
            if (at_end) begin
              // Counters stay on the last pixel while it drains.
              pix_last_reg <= 1'b1;
              state_reg    <= DRAIN;
            end else if (cx_reg == CX_MAX) begin
              cx_reg <= '0;
              cy_reg <= cy_reg + 1'b1;
            end else begin
              cx_reg <= cx_reg + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (bus.pix_ready) begin
            pix_valid_reg <= 1'b0;
            pix_last_reg  <= 1'b0;
            state_reg     <= IDLE;
            tri_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          tri_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tri_ready    = tri_ready_reg;
  assign bus.busy         = busy_reg;
  assign bus.ip_setup     = ip_setup_reg;
  assign bus.ip_fx1       = plane_reg[0];
  assign bus.ip_fx2       = plane_reg[1];
  assign bus.ip_fx3       = plane_reg[2];
  assign bus.ip_fy1       = plane_reg[3];
  assign bus.ip_fy2       = plane_reg[4];
  assign bus.ip_fy3       = plane_reg[5];
  assign bus.ip_fz1       = plane_reg[6];
  assign bus.ip_fz2       = plane_reg[7];
  assign bus.ip_fz3       = plane_reg[8];
  assign bus.ip_frac_bits = frac_reg;
  assign bus.ip_x         = ip_x_calc;
  assign bus.ip_y         = ip_y_calc;
  assign bus.pix_valid    = pix_valid_reg;
  assign bus.pix_last     = pix_last_reg;
  assign bus.pix_x        = pix_x_reg;
  assign bus.pix_y        = pix_y_reg;
  assign bus.pix_z        = pix_z_reg;

endmodule

// File: tb/tb_plane_tile_walker.sv
// tb_plane_tile_walker
//   Two walkers (SETUP_LAT=1 and SETUP_LAT=4) share clock, reset, command
//   data, abort and pix_ready; tri_valid and output observation are routed
//   to the walker selected by 'sel'. The interpolator is modelled as
//   ip_z = ip_x*1000 + ip_y. Expected pixels are queued when a triangle is
//   sent and popped on every pixel handshake.
module tb_plane_tile_walker;
  localparam int TW   = 32;
  localparam int TH   = 32;
  localparam int NPIX = TW * TH;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [31:0] z;
    logic        last;
  } pix_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  plane_tile_walker_if ifa ();
  plane_tile_walker_if ifb ();

  plane_tile_walker #(.TILE_W(TW), .TILE_H(TH), .SETUP_LAT(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  plane_tile_walker #(.TILE_W(TW), .TILE_H(TH), .SETUP_LAT(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // Stimulus variables
  logic        sel;
  logic        tv;
  logic        rdy;
  logic        abort_d;
  logic [31:0] vtx [9];
  logic [7:0]  frac_d;
  logic [5:0]  tx_d;
  logic [5:0]  ty_d;

  assign ifa.tri_valid = tv & ~sel;
  assign ifb.tri_valid = tv & sel;
  assign ifa.tri_fx1 = vtx[0];  assign ifb.tri_fx1 = vtx[0];
  assign ifa.tri_fx2 = vtx[1];  assign ifb.tri_fx2 = vtx[1];
  assign ifa.tri_fx3 = vtx[2];  assign ifb.tri_fx3 = vtx[2];
  assign ifa.tri_fy1 = vtx[3];  assign ifb.tri_fy1 = vtx[3];
  assign ifa.tri_fy2 = vtx[4];  assign ifb.tri_fy2 = vtx[4];
  assign ifa.tri_fy3 = vtx[5];  assign ifb.tri_fy3 = vtx[5];
  assign ifa.tri_fz1 = vtx[6];  assign ifb.tri_fz1 = vtx[6];
  assign ifa.tri_fz2 = vtx[7];  assign ifb.tri_fz2 = vtx[7];
  assign ifa.tri_fz3 = vtx[8];  assign ifb.tri_fz3 = vtx[8];
  assign ifa.tri_frac_bits = frac_d;  assign ifb.tri_frac_bits = frac_d;
  assign ifa.tri_tile_x = tx_d;  assign ifb.tri_tile_x = tx_d;
  assign ifa.tri_tile_y = ty_d;  assign ifb.tri_tile_y = ty_d;
  assign ifa.abort = abort_d;  assign ifb.abort = abort_d;
  assign ifa.pix_ready = rdy;  assign ifb.pix_ready = rdy;

  // Interpolator model
  assign ifa.ip_z = 32'(ifa.ip_x) * 32'sd1000 + 32'(ifa.ip_y);
  assign ifb.ip_z = 32'(ifb.ip_x) * 32'sd1000 + 32'(ifb.ip_y);

  // Observation of the selected walker
  logic        pv, pl, tr, bsy, ips;
  logic [11:0] px, py, ipx, ipy;
  logic [31:0] pz;
  logic [295:0] plane_a, plane_b, plane_obs;

  assign plane_a = {ifa.ip_fx1, ifa.ip_fx2, ifa.ip_fx3, ifa.ip_fy1, ifa.ip_fy2,
                    ifa.ip_fy3, ifa.ip_fz1, ifa.ip_fz2, ifa.ip_fz3, ifa.ip_frac_bits};
  assign plane_b = {ifb.ip_fx1, ifb.ip_fx2, ifb.ip_fx3, ifb.ip_fy1, ifb.ip_fy2,
                    ifb.ip_fy3, ifb.ip_fz1, ifb.ip_fz2, ifb.ip_fz3, ifb.ip_frac_bits};
  assign pv  = sel ? ifb.pix_valid : ifa.pix_valid;
  assign pl  = sel ? ifb.pix_last  : ifa.pix_last;
  assign tr  = sel ? ifb.tri_ready : ifa.tri_ready;
  assign bsy = sel ? ifb.busy      : ifa.busy;
  assign ips = sel ? ifb.ip_setup  : ifa.ip_setup;
  assign px  = sel ? ifb.pix_x     : ifa.pix_x;
  assign py  = sel ? ifb.pix_y     : ifa.pix_y;
  assign pz  = sel ? ifb.pix_z     : ifa.pix_z;
  assign ipx = sel ? ifb.ip_x      : ifa.ip_x;
  assign ipy = sel ? ifb.ip_y      : ifa.ip_y;
  assign plane_obs = sel ? plane_b : plane_a;

  // Scoreboard and monitor state
  pix_t         exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           tri_idx = 0;
  logic         prev_stalled;
  logic [80:0]  prev_payload;
  logic         plane_chk;
  logic [295:0] exp_plane;
  logic         spot_en;
  logic [56:0]  sp_first, sp_33, sp_last;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the
  // following rising edge, where the caller drives the next inputs.
  task automatic tick();
    pix_t e;
    @(negedge clock);
    if (prev_stalled) begin
      check("stall_valid_held", pv, 1);
      check("stall_payload_held", {px, py, pz, pl, ipx, ipy}, prev_payload);
    end
    if (pv && rdy) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pixel: observed x=%0d y=%0d required none", px, py);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pix_payload", {px, py, pz, pl}, {e.x, e.y, e.z, e.last});
        if (spot_en) begin
          if (tri_idx == 0)        check("spot_first", {px, py, pz, pl}, sp_first);
          if (tri_idx == 33)       check("spot_33",    {px, py, pz, pl}, sp_33);
          if (tri_idx == NPIX - 1) check("spot_last",  {px, py, pz, pl}, sp_last);
        end
      end
      tri_idx++;
    end
    prev_stalled = pv && !rdy;
    prev_payload = {px, py, pz, pl, ipx, ipy};
    if (plane_chk) check("plane_regs", plane_obs, exp_plane);
    @(posedge clock);
    #1;
  endtask

  task automatic send_tri(input logic [5:0] tx, input logic [5:0] ty, input logic [31:0] base);
    pix_t e;
    int x, y;
    for (int k = 0; k < 9; k++) vtx[k] = base + 32'(k * 7);
    frac_d = base[7:0] ^ 8'h5a;
    tx_d = tx;
    ty_d = ty;
    for (int cy = 0; cy < TH; cy++) begin
      for (int cx = 0; cx < TW; cx++) begin
        x = int'(tx) * TW + cx;
        y = int'(ty) * TH + cy;
        e.x = 12'(x);
        e.y = 12'(y);
        e.z = 32'(x * 1000 + y);
        e.last = (cx == TW - 1) && (cy == TH - 1);
        exp_q.push_back(e);
      end
    end
    tri_idx = 0;
    tv = 1'b1;
    check("tri_ready_before_accept", tr, 1);
    tick();
    tv = 1'b0;
    exp_plane = {vtx[0], vtx[1], vtx[2], vtx[3], vtx[4], vtx[5], vtx[6], vtx[7], vtx[8], frac_d};
    check("ip_setup_after_accept", ips, 1);
    check("busy_after_accept", bsy, 1);
    check("tri_ready_after_accept", tr, 0);
  endtask

  task automatic wait_first(input int lat);
    int n = 0;
    while (!pv && n < 40) begin
      tick();
      n++;
      check("ip_setup_single_cycle", ips, 0);
    end
    check("first_valid_latency", n, 1 + lat);
  endtask

  task automatic stream_b2b();
    int r0 = tri_idx;
    repeat (NPIX) tick();
    check("b2b_pixel_count", tri_idx - r0, NPIX);
    check("queue_empty", exp_q.size(), 0);
    check("end_pix_valid", pv, 0);
    check("end_pix_last", pl, 0);
    check("end_tri_ready", tr, 1);
    check("end_busy", bsy, 0);
  endtask

  initial begin
    int n;
    logic [295:0] saved_plane;
    sel = 1'b0; tv = 1'b0; rdy = 1'b1; abort_d = 1'b0;
    frac_d = '0; tx_d = '0; ty_d = '0;
    for (int k = 0; k < 9; k++) vtx[k] = '0;
    prev_stalled = 1'b0; prev_payload = '0;
    plane_chk = 1'b1; exp_plane = '0; spot_en = 1'b0;
    sp_first = '0; sp_33 = '0; sp_last = '0;
    reset = 1'b0;

    // Reset values, observed before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_tri_ready", tr, 1);
    check("rst_busy", bsy, 0);
    check("rst_ip_setup", ips, 0);
    check("rst_pix_valid", pv, 0);
    check("rst_pix_last", pl, 0);
    check("rst_pix_xyz", {px, py, pz}, 0);
    check("rst_ip_xy", {ipx, ipy}, 0);
    check("rst_plane", plane_obs, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Tile (0,0), back-to-back stream
    spot_en  = 1'b1;
    sp_first = {12'd0, 12'd0, 32'd0, 1'b0};
    sp_33    = {12'd1, 12'd1, 32'd1001, 1'b0};
    sp_last  = {12'd31, 12'd31, 32'd31031, 1'b1};
    send_tri(6'd0, 6'd0, 32'h1000_0000);
    wait_first(1);
    stream_b2b();

    // Tile (2,3)
    sp_first = {12'd64, 12'd96, 32'd64096, 1'b0};
    sp_33    = {12'd65, 12'd97, 32'd65097, 1'b0};
    sp_last  = {12'd95, 12'd127, 32'd95127, 1'b1};
    send_tri(6'd2, 6'd3, 32'hdead_0100);
    wait_first(1);
    stream_b2b();
    spot_en = 1'b0;

    // Pseudo-random back-pressure
    send_tri(6'd1, 6'd0, 32'h0000_7700);
    wait_first(1);
    n = 0;
    while ((exp_q.size() != 0 || pv) && n < 6000) begin
      rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rdy = 1'b1;
    check("random_drain_in_time", n < 6000, 1);
    check("random_pixel_count", tri_idx, NPIX);
    check("random_busy_end", bsy, 0);
    prev_stalled = 1'b0;

    // SETUP_LAT=4 walker
    saved_plane = exp_plane;
    exp_plane = '0;
    sel = 1'b1;
    send_tri(6'd0, 6'd1, 32'h0400_0040);
    wait_first(4);
    stream_b2b();
    sel = 1'b0;
    exp_plane = saved_plane;

    // Abort at pixel 500
    send_tri(6'd1, 6'd1, 32'h5555_0000);
    wait_first(1);
    n = 0;
    while (tri_idx < 500 && n < 2000) begin
      tick();
      n++;
    end
    abort_d = 1'b1;
    tick();
    abort_d = 1'b0;
    check("abort_pix_valid", pv, 0);
    check("abort_pix_last", pl, 0);
    check("abort_tri_ready", tr, 1);
    check("abort_busy", bsy, 0);
    check("abort_ip_setup", ips, 0);
    check("abort_ip_xy_counters_cleared", {ipx, ipy}, {12'd32, 12'd32});
    exp_q.delete();
    repeat (3) tick();
    send_tri(6'd0, 6'd0, 32'h0bad_f00d);
    wait_first(1);
    stream_b2b();

    // Reset asserted while stalled mid-walk
    send_tri(6'd3, 6'd2, 32'h7777_0001);
    wait_first(1);
    repeat (100) tick();
    rdy = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_pix_valid", pv, 0);
    check("midrst_pix_last", pl, 0);
    check("midrst_tri_ready", tr, 1);
    check("midrst_busy", bsy, 0);
    check("midrst_ip_setup", ips, 0);
    check("midrst_pix_xyz", {px, py, pz}, 0);
    check("midrst_ip_xy", {ipx, ipy}, 0);
    check("midrst_plane", plane_obs, 0);
    exp_q.delete();
    prev_stalled = 1'b0;
    exp_plane = '0;
    tri_idx = 0;
    repeat (2) tick();
    reset = 1'b0;
    rdy = 1'b1;
    repeat (20) tick();
    check("post_reset_no_pixels", tri_idx, 0);
    check("post_reset_pix_valid", pv, 0);
    check("post_reset_busy", bsy, 0);
    check("post_reset_tri_ready", tr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "time limit");
  end

endmodule
